usb_txn_ctrl: RTL and testbench

USB_TXN_CTRL -- requirements
Module: usb_txn_ctrl

---
 rtl/usb_pkg.sv | 39 +++
 rtl/usb_txn_ctrl_if.sv | 30 +++
 rtl/usb_txn_ctrl_timer.sv | 32 +++
 rtl/usb_txn_ctrl.sv | 165 ++++++++++++++++
 tb/tb_usb_txn_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared types for the USB transaction controller: packet IDs, transaction
// status codes and controller states, plus a helper that picks the DATA PID
// for the current toggle.
package usb_pkg;

  typedef enum logic [2:0] {
    PID_NONE  = 3'd0,
    PID_OUT   = 3'd1,
    PID_IN    = 3'd2,
    PID_DATA0 = 3'd3,
    PID_DATA1 = 3'd4,
    PID_ACK   = 3'd5,
    PID_NAK   = 3'd6,
    PID_STALL = 3'd7
  } pid_e;

  typedef enum logic [1:0] {
    TXN_OK      = 2'd0,
    TXN_NAKED   = 2'd1,
    TXN_ERROR   = 2'd2,
    TXN_TIMEOUT = 2'd3
  } txn_status_e;

  typedef enum logic [2:0] {
    S_IDLE          = 3'd0,
    S_OUT_WAIT_DATA = 3'd1,
    S_SEND_HS       = 3'd2,
    S_IN_SEND_DATA  = 3'd3,
    S_IN_WAIT_ACK   = 3'd4,
    S_TX_BUSY       = 3'd5,
    S_FINISH        = 3'd6
  } state_e;

  // DATA0 for toggle 0, DATA1 for toggle 1
  function automatic pid_e data_pid(input logic toggle);
    return toggle ? PID_DATA1 : PID_DATA0;
  endfunction

endpackage

// File: rtl/usb_txn_ctrl_if.sv
// Receiver / transmitter / buffer-side signals of the transaction controller.
// The controller uses the slave view; the surrounding logic uses master.
interface usb_txn_ctrl_if;

  logic [2:0] rx_packet;
  logic       rx_done;
  logic       rx_error;
  logic [6:0] buffer_occupancy;
  logic       host_tx_ready;
  logic [2:0] tx_packet;
  logic       tx_start;
  logic       tx_transfer_active;
  logic       flush;
  logic       txn_done;
  logic [1:0] txn_status;
  logic       data_toggle;

  modport slave (
    input  rx_packet, rx_done, rx_error, buffer_occupancy, host_tx_ready,
           tx_transfer_active,
    output tx_packet, tx_start, flush, txn_done, txn_status, data_toggle
  );

  modport master (
    output rx_packet, rx_done, rx_error, buffer_occupancy, host_tx_ready,
           tx_transfer_active,
    input  tx_packet, tx_start, flush, txn_done, txn_status, data_toggle
  );

endinterface

// File: rtl/usb_txn_ctrl_timer.sv
// Idle-wait timer for the transaction controller. Only built when
// USB_TXN_TIMEOUT_EN is defined. Counts cycles while 'run' is high, clears
// whenever 'run' is low (so it restarts on every entry to a wait state).
`ifdef USB_TXN_TIMEOUT_EN
module usb_txn_timer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd800
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run,
  output logic expired
);

  logic [15:0] count_r;

  // wait-cycle counter, saturating so it can never wrap back to zero
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count_r <= 16'd0;
    end else if (!run) begin
      count_r <= 16'd0;
    end else if (count_r != 16'hFFFF) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = run && (count_r == TIMEOUT_CYCLES);

endmodule
`endif

// File: rtl/usb_txn_ctrl.sv
// USB device transaction controller: sequences OUT and IN transactions,
// issues handshakes / data PIDs to the transmitter, tracks the data toggle
// and reports a status per completed transaction.
// Optional feature: define USB_TXN_TIMEOUT_EN to abort wait states after
// TIMEOUT_CYCLES idle cycles (status TIMEOUT).
module usb_txn_ctrl
  import usb_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd800,
  parameter int          MAX_PKT        = 64
) (
  input  logic               clk,
  input  logic               n_rst,
  usb_txn_ctrl_if.slave      bus
);

  localparam logic [6:0] MAX_OCC = 7'(MAX_PKT);

  state_e      state_r;
  pid_e        tx_packet_r;
  logic        tx_start_r;
  logic        flush_r;
  logic        txn_done_r;
  logic        data_toggle_r;
  logic        in_data_r;      // current transmission is IN data, not a handshake
  txn_status_e status_r;
  txn_status_e pend_r;         // status to report once the handshake has gone out

  logic rx_good_s;
  logic occ_over_s;
  logic waiting_s;
  logic timeout_hit_s;

  assign rx_good_s  = bus.rx_done && !bus.rx_error;
  assign occ_over_s = bus.buffer_occupancy > MAX_OCC;
  assign waiting_s  = (state_r == S_OUT_WAIT_DATA) || (state_r == S_IN_WAIT_ACK);

`ifdef USB_TXN_TIMEOUT_EN
  usb_txn_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .n_rst   (n_rst),
    .run     (waiting_s),
    .expired (timeout_hit_s)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, waiting_s};
  assign timeout_hit_s      = 1'b0;
`endif

  // transaction state machine; all outputs are registered here
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r       <= S_IDLE;
      tx_packet_r   <= PID_NONE;
      tx_start_r    <= 1'b0;
      flush_r       <= 1'b0;
      txn_done_r    <= 1'b0;
      data_toggle_r <= 1'b0;
      in_data_r     <= 1'b0;
      status_r      <= TXN_OK;
      pend_r        <= TXN_OK;
    end else begin
      tx_start_r <= 1'b0;
      flush_r    <= 1'b0;
      txn_done_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (rx_good_s && (bus.rx_packet == PID_OUT)) begin
            state_r <= S_OUT_WAIT_DATA;
          end else if (rx_good_s && (bus.rx_packet == PID_IN)) begin
            tx_start_r <= 1'b1;
            if (bus.host_tx_ready) begin
              state_r     <= S_IN_SEND_DATA;
              tx_packet_r <= data_pid(data_toggle_r);
              in_data_r   <= 1'b1;
            end else begin
              state_r     <= S_SEND_HS;
              tx_packet_r <= PID_NAK;
              in_data_r   <= 1'b0;
              pend_r      <= TXN_NAKED;
            end
          end
        end
        S_OUT_WAIT_DATA: begin
          if (bus.rx_done) begin
            if (bus.rx_error || occ_over_s) begin
              flush_r    <= 1'b1;
              txn_done_r <= 1'b1;
              status_r   <= TXN_ERROR;
              state_r    <= S_FINISH;
            end else if ((bus.rx_packet == PID_DATA0) || (bus.rx_packet == PID_DATA1)) begin
              state_r     <= S_SEND_HS;
              tx_packet_r <= PID_ACK;
              tx_start_r  <= 1'b1;
              in_data_r   <= 1'b0;
              pend_r      <= TXN_OK;
              // matching toggle: new data; mismatch: duplicate, drop it
              if ((bus.rx_packet == PID_DATA1) == data_toggle_r) begin
                data_toggle_r <= ~data_toggle_r;
              end else begin
                flush_r <= 1'b1;
              end
            end else begin
              txn_done_r <= 1'b1;
              status_r   <= TXN_ERROR;
              state_r    <= S_FINISH;
            end
          end else if (timeout_hit_s) begin
            flush_r    <= 1'b1;
            txn_done_r <= 1'b1;
            status_r   <= TXN_TIMEOUT;
            state_r    <= S_FINISH;
          end
        end
        S_SEND_HS, S_IN_SEND_DATA: begin
          state_r <= S_TX_BUSY;
        end
        S_TX_BUSY: begin
          if (!bus.tx_transfer_active) begin
            tx_packet_r <= PID_NONE;
            if (in_data_r) begin
              state_r <= S_IN_WAIT_ACK;
            end else begin
              txn_done_r <= 1'b1;
              status_r   <= pend_r;
              state_r    <= S_FINISH;
            end
          end
        end
        S_IN_WAIT_ACK: begin
          if (bus.rx_done) begin
            txn_done_r <= 1'b1;
            state_r    <= S_FINISH;
            if (rx_good_s && (bus.rx_packet == PID_ACK)) begin
              data_toggle_r <= ~data_toggle_r;
              status_r      <= TXN_OK;
            end else begin
              status_r <= TXN_ERROR;
            end
          end else if (timeout_hit_s) begin
            txn_done_r <= 1'b1;
            status_r   <= TXN_TIMEOUT;
            state_r    <= S_FINISH;
          end
        end
        S_FINISH: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r     <= S_IDLE;
          tx_packet_r <= PID_NONE;
        end
      endcase
    end
  end

  assign bus.tx_packet   = tx_packet_r;
  assign bus.tx_start    = tx_start_r;
  assign bus.flush       = flush_r;
  assign bus.txn_done    = txn_done_r;
  assign bus.txn_status  = status_r;
  assign bus.data_toggle = data_toggle_r;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Self-checking bench for usb_txn_ctrl: a directed vector table, a reset
// mid-transaction sequence, optional timeout sequences (USB_TXN_TIMEOUT_EN)
// and randomized transactions checked against a rule-level model.
module tb_usb_txn_ctrl;
  import usb_pkg::*;

  localparam int K_OUT  = 0;
  localparam int K_IN   = 1;
  localparam int K_JUNK = 2;

  typedef struct {
    int kind;      // K_OUT / K_IN / K_JUNK
    int pid;       // OUT: data PID; JUNK: token PID sent in IDLE
    bit err;       // OUT: error on data; JUNK: error on token
    int occ;
    bit ready;
    int ack_pid;
    bit ack_err;
    bit silent;    // host never answers
    int e_tx;      // expected number of tx_start pulses
    int e_txpid;
    int e_flush;
    int e_done;
    int e_status;
    int e_toggle;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_txn_ctrl_if bus ();

  usb_txn_ctrl #(.TIMEOUT_CYCLES(16'd800), .MAX_PKT(64)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int kind, int pid, bit err, int occ, bit ready, int ack_pid,
                              bit ack_err, bit silent, int e_tx, int e_txpid, int e_flush,
                              int e_done, int e_status, int e_toggle);
    vec_t v;
    v.kind = kind; v.pid = pid; v.err = err; v.occ = occ; v.ready = ready;
    v.ack_pid = ack_pid; v.ack_err = ack_err; v.silent = silent;
    v.e_tx = e_tx; v.e_txpid = e_txpid; v.e_flush = e_flush; v.e_done = e_done;
    v.e_status = e_status; v.e_toggle = e_toggle;
    return v;
  endfunction

  // Rule-level reference: what one transaction should produce, given the
  // current toggle and the last reported status.
  function automatic vec_t predict(vec_t v, int tog, int last_st);
    vec_t r = v;
    r.e_tx = 0; r.e_txpid = 0; r.e_flush = 0; r.e_done = 0;
    r.e_status = last_st; r.e_toggle = tog;
    if (v.kind == K_OUT) begin
      r.e_done = 1;
      if (v.silent) begin
        r.e_flush = 1; r.e_status = 3;
      end else if (v.err || v.occ > 64) begin
        r.e_flush = 1; r.e_status = 2;
      end else begin
        r.e_tx = 1; r.e_txpid = 5; r.e_status = 0;
        if ((v.pid == 4 ? 1 : 0) == tog) r.e_toggle = 1 - tog;
        else r.e_flush = 1;
      end
    end else if (v.kind == K_IN) begin
      r.e_done = 1; r.e_tx = 1;
      if (!v.ready) begin
        r.e_txpid = 6; r.e_status = 1;
      end else begin
        r.e_txpid = (tog == 1) ? 4 : 3;
        if (v.silent) r.e_status = 3;
        else if (v.ack_pid == 5 && !v.ack_err) begin
          r.e_status = 0; r.e_toggle = 1 - tog;
        end else r.e_status = 2;
      end
    end
    return r;
  endfunction

  // Plays host, buffer and transmitter for one transaction and compares.
  task automatic run_txn(input vec_t v, input string tag);
    int n_tx = 0, tx_pid = 0, n_flush = 0, n_done = 0;
    int busy = 0, ack_at = -1, post = -1, budget;
    budget = (v.kind == K_JUNK) ? 12 : (v.silent ? 1200 : 80);
    bus.buffer_occupancy = 7'(v.occ);
    bus.host_tx_ready    = v.ready;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_start) begin
        n_tx++;
        if (n_tx == 1) tx_pid = int'(bus.tx_packet);
        busy = 3;
        bus.tx_transfer_active = 1'b1;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          bus.tx_transfer_active = 1'b0;
          if (v.kind == K_IN && v.ready && !v.silent) ack_at = i + 3;
        end
      end
      if (bus.flush) n_flush++;
      if (bus.txn_done) begin
        n_done++;
        if (post < 0) post = i + 2;
      end
      bus.rx_done = 1'b0; bus.rx_error = 1'b0; bus.rx_packet = 3'd0;
      if (i == 0) begin
        bus.rx_packet = (v.kind == K_OUT) ? 3'd1 : (v.kind == K_IN) ? 3'd2 : 3'(v.pid);
        bus.rx_error  = (v.kind == K_JUNK) ? v.err : 1'b0;
        bus.rx_done   = 1'b1;
      end else if (i == 2 && v.kind == K_OUT && !v.silent) begin
        bus.rx_packet = 3'(v.pid); bus.rx_error = v.err; bus.rx_done = 1'b1;
      end else if (i == ack_at) begin
        bus.rx_packet = 3'(v.ack_pid); bus.rx_error = v.ack_err; bus.rx_done = 1'b1;
      end
      if (post >= 0 && i >= post) break;
    end
    check({tag, ".tx_starts"}, n_tx, v.e_tx);
    if (v.e_tx > 0) check({tag, ".tx_pid"}, tx_pid, v.e_txpid);
    check({tag, ".flushes"}, n_flush, v.e_flush);
    check({tag, ".dones"}, n_done, v.e_done);
    check({tag, ".status"}, bus.txn_status, v.e_status);
    check({tag, ".toggle"}, bus.data_toggle, v.e_toggle);
  endtask

  vec_t tbl[$];
  vec_t rv;
  int   model_tog;
  int   model_st;
  int   dones;

  initial begin
    bus.rx_packet = 3'd0; bus.rx_done = 1'b0; bus.rx_error = 1'b0;
    bus.buffer_occupancy = 7'd0; bus.host_tx_ready = 1'b0;
    bus.tx_transfer_active = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.tx_packet", bus.tx_packet, 0);
    check("reset.tx_start", bus.tx_start, 0);
    check("reset.flush", bus.flush, 0);
    check("reset.txn_done", bus.txn_done, 0);
    check("reset.status", bus.txn_status, 0);
    check("reset.toggle", bus.data_toggle, 0);
    n_rst = 1'b1;

    //              kind   pid err occ rdy ack er sil  tx pid fl dn st tg
    tbl.push_back(mk(K_OUT, 3, 0,  8, 0, 0, 0, 0,  1, 5, 0, 1, 0, 1));
    tbl.push_back(mk(K_OUT, 3, 0,  8, 0, 0, 0, 0,  1, 5, 1, 1, 0, 1));
    tbl.push_back(mk(K_IN,  0, 0,  0, 0, 0, 0, 0,  1, 6, 0, 1, 1, 1));
    tbl.push_back(mk(K_OUT, 4, 1,  8, 0, 0, 0, 0,  0, 0, 1, 1, 2, 1));
    tbl.push_back(mk(K_OUT, 4, 0, 65, 0, 0, 0, 0,  0, 0, 1, 1, 2, 1));
    tbl.push_back(mk(K_OUT, 4, 0, 64, 0, 0, 0, 0,  1, 5, 0, 1, 0, 0));
    tbl.push_back(mk(K_IN,  0, 0,  0, 1, 5, 0, 0,  1, 3, 0, 1, 0, 1));
    tbl.push_back(mk(K_IN,  0, 0,  0, 1, 6, 0, 0,  1, 4, 0, 1, 2, 1));
    tbl.push_back(mk(K_JUNK,3, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 1));
    tbl.push_back(mk(K_JUNK,1, 1,  0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 1));
    tbl.push_back(mk(K_IN,  0, 0,  0, 1, 5, 1, 0,  1, 4, 0, 1, 2, 1));
    tbl.push_back(mk(K_IN,  0, 0,  0, 1, 5, 0, 0,  1, 4, 0, 1, 0, 0));
    tbl.push_back(mk(K_JUNK,5, 0,  0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(K_JUNK,2, 1,  0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // reset while the transmitter is busy: toggle=1, status=NAKED beforehand
    run_txn(mk(K_OUT, 3, 0, 4, 0, 0, 0, 0, 1, 5, 0, 1, 0, 1), "prerst0");
    run_txn(mk(K_IN,  0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 1, 1, 1), "prerst1");
    bus.host_tx_ready = 1'b1;
    @(negedge clk);
    bus.rx_packet = 3'd2; bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0; bus.rx_packet = 3'd0;
    check("midrst.tx_start", bus.tx_start, 1);
    check("midrst.tx_pid", bus.tx_packet, 4);
    bus.tx_transfer_active = 1'b1;
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check("midrst.tx_packet", bus.tx_packet, 0);
    check("midrst.tx_start", bus.tx_start, 0);
    check("midrst.flush", bus.flush, 0);
    check("midrst.txn_done", bus.txn_done, 0);
    check("midrst.status", bus.txn_status, 0);
    check("midrst.toggle", bus.data_toggle, 0);
    n_rst = 1'b1;
    bus.tx_transfer_active = 1'b0;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.txn_done) dones++;
    end
    check("midrst.no_done", dones, 0);
    model_tog = 0;
    model_st  = 0;

`ifdef USB_TXN_TIMEOUT_EN
    run_txn(mk(K_IN,  0, 0, 0, 1, 0, 0, 1, 1, 3, 0, 1, 3, 0), "tmo_in");
    run_txn(mk(K_OUT, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 3, 0), "tmo_out");
    model_st = 3;
`endif

    for (int n = 0; n < 40; n++) begin
      int r;
      rv = mk(K_JUNK, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      r = int'($urandom_range(0, 9));
      if (r < 4) begin
        rv.kind = K_OUT;
        rv.pid  = ($urandom_range(0, 1) == 1) ? 4 : 3;
        rv.err  = ($urandom_range(0, 5) == 0);
        rv.occ  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65, 127))
                                              : int'($urandom_range(0, 64));
      end else if (r < 8) begin
        rv.kind  = K_IN;
        rv.ready = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: rv.ack_err = 1'b1;
          1: rv.ack_pid = ($urandom_range(0, 1) == 1) ? 6 : 7;
          default: rv.ack_pid = 5;
        endcase
      end else begin
        rv.pid = int'($urandom_range(0, 7));
        rv.err = (rv.pid == 1 || rv.pid == 2) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      rv = predict(rv, model_tog, model_st);
      run_txn(rv, $sformatf("rnd%0d", n));
      model_tog = rv.e_toggle;
      model_st  = rv.e_status;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
